// File: rtl/decoder_scan_sequencer.sv
// decoder_scan_sequencer: steps a 4-to-16 decoder through its masked channels with break-before-make dwell timing
// Ports:
//   clk, rst_n            clock (rising edge) and synchronous active-low reset
//   start, stop           scan handshake; start is sampled in IDLE only, stop aborts any scan and beats start
//   continuous, dwell,    scan configuration, captured when a scan starts
//   mask                  (bit i of mask enables decoder output i; dwell = enable-high cycles minus 1)
//   sel, sel_en           decoder select and enable, registered
//   busy, done,           scan in progress / single-shot frame finished pulse /
//   frame_wrap            continuous frame restart pulse
module decoder_scan_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               continuous,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [15:0]        mask,
    output logic [3:0]         sel,
    output logic               sel_en,
    output logic               busy,
    output logic               done,
    output logic               frame_wrap
);
    typedef enum logic [1:0] {IDLE, SEEK, DWELL} state_t;
    state_t state_q, state_d;
    logic [3:0] idx_q, idx_d, sel_q, sel_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d, dwell_q, dwell_d;
    logic [15:0] mask_q, mask_d;
    logic cont_q, cont_d;
    logic sel_en_q, sel_en_d, busy_q, busy_d, done_q, done_d, wrap_q, wrap_d;
    logic eof, null_start;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            mask_q   <= '0;
            dwell_q  <= '0;
            cont_q   <= 1'b0;
            sel_q    <= '0;
            sel_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            dwell_q  <= dwell_d;
            cont_q   <= cont_d;
            sel_q    <= sel_d;
            sel_en_q <= sel_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            wrap_q   <= wrap_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        mask_d     = mask_q;
        dwell_d    = dwell_q;
        cont_d     = cont_q;
        eof        = 1'b0;
        null_start = 1'b0;
        case (state_q)
            IDLE: if (start && !stop) begin
                mask_d     = mask;
                dwell_d    = dwell;
                cont_d     = continuous;
                idx_d      = '0;
                null_start = (mask == '0);
                state_d    = null_start ? IDLE : SEEK;
            end
            SEEK: if (mask_q[idx_q]) begin
                state_d = DWELL;
                cnt_d   = dwell_q;
            end else if (idx_q != 4'd15) begin
                idx_d = idx_q + 4'd1;
            end else begin
                eof = 1'b1;
            end
            DWELL: if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else if (idx_q != 4'd15) begin
                idx_d   = idx_q + 4'd1;
                state_d = SEEK;
            end else begin
                eof = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (eof) begin
            idx_d   = '0;
            state_d = cont_q ? SEEK : IDLE;
        end
        // stop overrides every transition out of a running state, including end of frame
        if (state_q != IDLE && stop) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end
    end

    // outputs are registered copies of what the next state implies; sel only moves while enable is low
    always_comb begin
        busy_d   = (state_d != IDLE);
        sel_en_d = (state_d == DWELL);
        sel_d    = (state_d == DWELL) ? idx_q : (state_d == IDLE) ? 4'd0 : sel_q;
        done_d   = null_start || (eof && !cont_q && !stop);
        wrap_d   = eof && cont_q && !stop;
    end

    assign sel        = sel_q;
    assign sel_en     = sel_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign frame_wrap = wrap_q;
endmodule

// File: doc/decoder_scan_sequencer.md
Name: decoder_scan_sequencer

Overview:
Sequencer that sits directly upstream of the 4-to-16 decoder. It drives the decoder's 4-bit select and enable inputs, stepping through the 16 decoder outputs in ascending order. Each enabled channel is held for a programmable dwell time. Channels are chosen by a mask. The block runs single-shot or continuous scans with a start/stop/done handshake and guarantees break-before-make: enable is always low between consecutive channels.

Parameters:
DWELL_W, 8, width of the dwell count input and the internal dwell counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  begin a scan; sampled only in IDLE
stop  input  1  abort the scan; honoured in any non-IDLE state
continuous  input  1  1 = repeat frames until stop; 0 = single frame; latched at start
dwell  input  DWELL_W  enable-high time per channel, minus 1; latched at start
mask  input  16  channel enables, bit i = decoder output i; latched at start
sel  output  4  to decoder a[3:0]; current channel index
sel_en  output  1  to decoder en
busy  output  1  high while a scan is in progress
done  output  1  one-cycle pulse when a single-shot frame completes
frame_wrap  output  1  one-cycle pulse when a continuous frame wraps 15->0

Behaviour:
- Interface: one clock; reset is synchronous and active-low (ports clk and rst_n).
- All outputs are registered.
- Reset (rst_n=0 at a clk edge) forces these values, regardless of state: state=IDLE, sel=0, sel_en=0, busy=0, done=0, frame_wrap=0, internal idx=0, cnt=0. A reset mid-scan aborts the scan with no done pulse.
- States: IDLE, SEEK, DWELL.
- IDLE:
  - Holds sel=0, sel_en=0, busy=0.
  - start=1 and stop=0: latch mask, dwell and continuous; idx=0.
  - If the latched mask is non-zero: go to SEEK, busy=1.
  - If the latched mask is 0: stay in IDLE, pulse done next cycle, busy stays 0.
  - stop=1 with start=1: stop wins and start is ignored.
- SEEK (sel_en=0, exactly 1 cycle per index):
  - mask_q[idx]=1: go to DWELL with sel=idx, sel_en=1, cnt=dwell_q.
  - Else, idx<15: idx=idx+1, stay in SEEK.
  - Else, idx=15: end of frame.
- DWELL (sel_en=1):
  - cnt>0: cnt=cnt-1.
  - cnt=0: sel_en=0. If idx<15: idx=idx+1, go to SEEK. If idx=15: end of frame.
  - sel_en is therefore high for exactly dwell_q+1 cycles per channel (dwell=0 gives 1 cycle).
- End of frame:
  - continuous_q=1: idx=0, go to SEEK, frame_wrap=1 for one cycle, busy stays 1.
  - continuous_q=0: go to IDLE, busy=0, sel=0, done=1 for one cycle, coincident with the first cycle busy is low.
- stop=1 in SEEK or DWELL: next cycle is IDLE with sel_en=0, busy=0, sel=0, no done, no frame_wrap.
- start while busy: ignored.
- Changes to mask, dwell or continuous while busy: no effect until the next start.
- Cycle cost per channel: enabled channel = 1 SEEK + (dwell_q+1) DWELL cycles; masked-off channel = 1 cycle. Full-mask frame = 16*(dwell_q+2) cycles.
- sel changes only while sel_en=0. sel_en is never high for two different sel values without at least one low cycle between them.
- Counter width DWELL_W. No wrap: cnt only decrements and stops at 0.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with start=1 -> sel=0, sel_en=0, busy=0, done=0, frame_wrap=0 throughout. Release mid-scan -> scan aborted, no done.
- Single-shot, mask=0xFFFF, dwell=2 -> sel_en high 3 cycles for each of sel=0..15 in order, with 1 low cycle before each channel. busy high exactly 64 cycles. done pulses once, in the first cycle busy is low.
- Sparse mask=0x8001, dwell=0 -> sel_en 1-cycle pulses at sel=0 then sel=15. busy high 18 cycles, then done.
- Continuous, mask=0x0003, dwell=1 -> frame period 1+2+1+2+14 = 20 cycles. frame_wrap pulses every 20 cycles. Assert stop while sel_en=1 -> sel_en and busy low next cycle, no done.
- mask=0 with start -> done pulse next cycle, busy never high, sel_en never high.
- start pulsed mid-scan, and dwell/mask changed mid-scan -> no restart, timing unchanged. stop and start together in IDLE -> stays IDLE.
